queue_fifo_thermo: RTL
======================

// Module: queue_fifo_thermo
// PURPOSE
// - Parametrised synchronous FIFO. Occupancy is held as a DEPTH-bit thermometer vector and binary-encoded on output.
// - Generalises the fixed 4-entry occupancy decode to any depth.
// - Adds push/pop handshakes, full/empty flags, count and a sticky error flag.
// - Sits between the producer and consumer stages of the memory/request path as the standard queue primitive.
// PARAMETERS
// - WIDTH  64  data bits per entry.
// - DEPTH  4   number of entries; legal range 2..64, any integer (not limited to powers of 2).
// - CW     localparam = $clog2(DEPTH+1); width of the count output.
// - AF_LVL DEPTH-1  almost-full threshold; used only when QUEUE_ALMOST_EN is defined.
// - AE_LVL 1        almost-empty threshold; used only when QUEUE_ALMOST_EN is defined.
// PORTS
// - clk           in   1      single clock; all state updates on the rising edge.
// - rst           in   1      synchronous, active-high reset.
// - data_in       in   WIDTH  write data.
// - push          in   1      write request.
// - pop           in   1      read request.
// - data_out      out  WIDTH  head entry, show-ahead; valid only while empty==0.
// - full          out  1      occ[DEPTH-1]==1.
// - empty         out  1      occ[0]==0.
// - count         out  CW     number of valid entries, 0..DEPTH.
// - err           out  1      sticky error flag.
// - almost_full   out  1      present only with QUEUE_ALMOST_EN.
// - almost_empty  out  1      present only with QUEUE_ALMOST_EN.
// BEHAVIOUR
// - Reset (rst=1 at the clock edge): occ=0, wr_ptr=0, rd_ptr=0, err=0.
//   - Outputs: empty=1, full=0, count=0, data_out=0 (forced while empty).
//   - Storage contents are not reset.
// - Occupancy: occ[i]=1 iff more than i entries are held. Legal patterns are contiguous ones from bit 0 only.
// - Accepted events:
//   - push_ok = push & (~full | pop).
//   - pop_ok  = pop & ~empty.
//   - A pop on a full FIFO frees a slot in the same cycle.
//   - A push on an empty FIFO does NOT bypass to a same-cycle pop.
// - Accepted push only: mem[wr_ptr]<=data_in; occ<={occ[DEPTH-2:0],1'b1}; wr_ptr advances.
// - Accepted pop only: occ<={1'b0,occ[DEPTH-1:1]}; rd_ptr advances.
// - Both accepted: write and read both occur; occ is unchanged; both pointers advance.
// - Pointer wrap: DEPTH-1 -> 0 by explicit compare, so non-power-of-2 depths are supported.
// - Latency: data pushed at edge N appears on data_out after edge N when the FIFO was empty. Flags and count update on the same edge as occ.
// - count is the combinational popcount of occ (thermometer-to-binary encode). Width CW; never exceeds DEPTH.
// - err is set (and held until rst) on any of:
//   - push & full & ~pop: push dropped, state unchanged.
//   - pop & empty: pop ignored. If push is also high, the push is still accepted.
//   - occ holds a non-thermometer pattern (integrity check).
// - Reset asserted mid-operation discards all entries in one cycle. Push/pop in that cycle are ignored.
// CONFIGURATION
// - QUEUE_ALMOST_EN defined:
//   - almost_full  = (count >= AF_LVL).
//   - almost_empty = (count <= AE_LVL).
//   - Both are combinational from occ; reset values are almost_full=0, almost_empty=1.
// - QUEUE_ALMOST_EN undefined: neither port exists and no threshold logic is built.
// TESTING
// - T1, reset: rst=1 for 2 cycles -> empty=1, full=0, count=0, err=0, data_out=0.
// - T2, fill/drain (DEPTH=4, WIDTH=64): push 0xA0..0xA3 on 4 edges -> count=4, full=1.
//   Then pop 4 times -> data_out A0,A1,A2,A3 in order; empty=1; err=0.
// - T3, full with push+pop: on a full FIFO, push=1 with 0xB0 and pop=1 -> count stays 4, A0 is removed, 0xB0 is written at the tail, err=0.
// - T4, overflow/underflow: push on full with pop=0 -> err=1, count stays 4.
//   Reset, then pop on empty -> err=1, count=0.
// - T5, wrap at DEPTH=5: 12 push/pop pairs with random data -> FIFO order preserved, count never exceeds 5.
// - T6, QUEUE_ALMOST_EN with AF_LVL=3, AE_LVL=1: count 0..4 -> almost_full rises at count=3, almost_empty falls at count=2.

Source files
------------

// File: rtl/queue_fifo_thermo.sv
// Parametrised synchronous FIFO whose occupancy is tracked as a DEPTH-bit thermometer vector.
// Define QUEUE_ALMOST_EN to build the almost_full/almost_empty outputs and their AF_LVL/AE_LVL thresholds.
module queue_fifo_thermo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4
`ifdef QUEUE_ALMOST_EN
    ,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         push,
    input  logic                         pop,
    output logic [WIDTH-1:0]             data_out,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
`ifdef QUEUE_ALMOST_EN
    ,
    output logic                         almost_full,
    output logic                         almost_empty
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] occ_nxt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ_count;
    logic             push_ok;
    logic             pop_ok;
    logic             occ_bad;
    logic             err_evt;

    assign full    = occ[DEPTH-1];
    assign empty   = ~occ[0];
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // A legal thermometer is 2^n-1, so adding one clears every set bit.
    assign occ_bad = |(occ & (occ + DEPTH'(1)));
    assign err_evt = (push & full & ~pop) | (pop & empty) | occ_bad;

    always_comb begin
        occ_nxt = occ;
        if (push_ok && !pop_ok) begin
            occ_nxt = {occ[DEPTH-2:0], 1'b1};
        end else if (pop_ok && !push_ok) begin
            occ_nxt = {1'b0, occ[DEPTH-1:1]};
        end
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (err_evt) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + CW'(occ[i]);
        end
    end

    assign count    = occ_count;
    assign data_out = empty ? '0 : mem[rd_ptr];

`ifdef QUEUE_ALMOST_EN
    assign almost_full  = (occ_count >= CW'(AF_LVL));
    assign almost_empty = (occ_count <= CW'(AE_LVL));
`endif

endmodule
